generator_pwm_motor: RTL
========================

Name: generator_pwm_motor

Overview:
- Downstream stage of the motion-logic block; consumes its per-driver direction codes (2 bit) and duty compare values (12 bit).
- Produces the enable (PWM) and IN1/IN2 pins for a dual H-bridge (drivers A and B).
- Contains the shared PWM period counter, glitch-free duty latching at period wrap, and a per-channel dead-time state machine on direction reversal.
- Clocked by the 50 MHz board clock.

Parameters:
- PERIOD, 1000, PWM period in clk cycles; counter runs 0..PERIOD-1.
- DEAD_CYCLES, 50, clk cycles both bridge inputs held low with enable low between direction changes.
- RAMP_STEP, 25, duty increment per period when soft start is enabled.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- directie_driverA  in  2  requested direction A: 10 forward, 01 reverse, 00 stop, 11 brake
- directie_driverB  in  2  same, driver B
- factor_dc_driverA  in  12  duty compare value A
- factor_dc_driverB  in  12  duty compare value B
- pwm_a  out  1  enable pin driver A
- pwm_b  out  1  enable pin driver B
- in1_a, in2_a  out  1 each  bridge inputs driver A
- in1_b, in2_b  out  1 each  bridge inputs driver B
- perioada_tick  out  1  one-cycle pulse when the counter wraps PERIOD-1 -> 0
- mort_activ  out  1  high while either channel is in DEAD

Behaviour:
- Reset (async, rst_n=0):
  - counter = 0.
  - Latched duties = 0.
  - Both channels in STOP with applied direction 00.
  - All outputs = 0.
- Counter:
  - Increments every clk; wraps at PERIOD-1.
  - perioada_tick is registered and high in the cycle where counter==PERIOD-1.
- Duty latch:
  - factor_dc_driverX is captured only on the cycle counter wraps to 0, so no mid-period change is possible.
  - Any value >= PERIOD saturates to 100% (pwm constantly 1). Current upstream values 0x998 and 0x750 both saturate; this is intended.
  - Value 0 gives a constant 0.
- PWM compare:
  - Raw PWM = (counter < duty_latched); registered, so 1 cycle latency from counter.
- Channel FSM (independent per channel; states RUN, DEAD, STOP, BRAKE):
  - Direction input is compared every cycle against the applied direction. Any difference moves the channel to DEAD on the next clk.
  - DEAD:
    - in1=in2=0, pwm=0.
    - Dead counter counts DEAD_CYCLES clocks.
    - At expiry, the input value sampled that cycle is applied, with next state per the encoding below.
    - Input changes during DEAD do not restart the counter.
    - If the input returns to the previous direction during DEAD, dead time still completes.
  - Encoding on apply:
    - 10 -> RUN: in1=1, in2=0.
    - 01 -> RUN: in1=0, in2=1.
    - 00 -> STOP: in1=in2=0, pwm=0.
    - 11 -> BRAKE: in1=in2=1, pwm=1 (fast stop).
  - RUN: pwm = compare output.
  - From reset (applied 00), a first request 10 also passes through DEAD.
- mort_activ = OR of the two channels' DEAD state, registered.
- Simultaneous events: a wrap during DEAD still updates the latched duty; the new duty is used once RUN resumes.

Optional Feature:
- Macro: PORNIRE_LINA_EN.
- Defined: on entering RUN from DEAD, the effective duty starts at 0 and increases by RAMP_STEP at each wrap until it reaches the latched duty (clamped to the target). A target decrease takes effect immediately.
- Undefined: effective duty = latched duty. RAMP_STEP is unused.

Test Plan:
- Reset then release; hold dir 00, duty 500 -> all outputs 0 for 3000 cycles; perioada_tick pulses every 1000 cycles.
- dir A = 10, duty A = 500 (macro undefined) -> 50 cycles in1_a=in2_a=0 with mort_activ=1, then in1_a=1, in2_a=0; each subsequent period has exactly 500 pwm_a high cycles.
- Change duty A 500 -> 200 mid-period -> current period keeps 500 high cycles; next period has 200.
- In RUN forward, switch dir A to 01 -> pwm_a=0 and in1/in2=00 for exactly 50 cycles, then in2_a=1, in1_a=0; channel B unaffected.
- Duty 0x998 and duty 0 -> pwm constantly 1 and constantly 0 respectively; dir 11 -> in1=in2=pwm=1 after dead time.
- PORNIRE_LINA_EN defined, duty 100, dir 10 -> high counts per period 25, 50, 75, 100, 100; assert rst_n low mid-ramp -> all outputs 0 immediately.

Source files
------------

// File: rtl/generator_pwm_motor.sv
// Dual H-bridge PWM stage: shared period counter, wrap-latched duties, per-channel dead-time FSM.
// Optional soft start on entering RUN is compiled in with `define PORNIRE_LINA_EN.
module generator_pwm_motor #(
  parameter int unsigned PERIOD      = 1000,
  parameter int unsigned DEAD_CYCLES = 50
`ifdef PORNIRE_LINA_EN
  ,
  parameter int unsigned RAMP_STEP   = 25
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  directie_driverA,
  input  logic [1:0]  directie_driverB,
  input  logic [11:0] factor_dc_driverA,
  input  logic [11:0] factor_dc_driverB,
  output logic        pwm_a,
  output logic        pwm_b,
  output logic        in1_a,
  output logic        in2_a,
  output logic        in1_b,
  output logic        in2_b,
  output logic        perioada_tick,
  output logic        mort_activ
);

  localparam int unsigned CntW  = $clog2(PERIOD);
  localparam int unsigned DeadW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  typedef enum logic [1:0] {StStop, StDead, StRun, StBrake} ch_state_e;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wrap;
  logic            tick_q;
  logic            mort_q;

  assign wrap  = (cnt_q == CntW'(PERIOD - 1));
  assign cnt_d = wrap ? '0 : cnt_q + CntW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == CntW'(PERIOD - 1));
    end
  end

  logic [1:0]  dir_in  [2];
  logic [11:0] duty_in [2];
  logic [1:0]  pwm_v, in1_v, in2_v, dead_nxt;

  assign dir_in[0]  = directie_driverA;
  assign dir_in[1]  = directie_driverB;
  assign duty_in[0] = factor_dc_driverA;
  assign duty_in[1] = factor_dc_driverB;

  for (genvar c = 0; c < 2; c++) begin : g_ch
    ch_state_e        st_q, st_d;
    logic [1:0]       app_q, app_d;
    logic [DeadW-1:0] dead_q, dead_d;
    logic [11:0]      duty_sat, duty_q, duty_eff;
    logic             cmp_q;
    logic             pwm_c, in1_c, in2_c;

    // Anything at or above PERIOD is stored as PERIOD so the compare is always true.
    assign duty_sat = (duty_in[c] >= 12'(PERIOD)) ? 12'(PERIOD) : duty_in[c];

    always_comb begin
      st_d   = st_q;
      app_d  = app_q;
      dead_d = dead_q;
      if (st_q == StDead) begin
        // Input changes while dead are ignored; only the value at expiry is applied.
        if (dead_q == DeadW'(DEAD_CYCLES - 1)) begin
          app_d  = dir_in[c];
          dead_d = '0;
          case (dir_in[c])
            2'b10, 2'b01: st_d = StRun;
            2'b11:        st_d = StBrake;
            default:      st_d = StStop;
          endcase
        end else begin
          dead_d = dead_q + DeadW'(1);
        end
      end else if (dir_in[c] != app_q) begin
        st_d   = StDead;
        dead_d = '0;
      end
    end

    always_comb begin
      pwm_c = 1'b0;
      in1_c = 1'b0;
      in2_c = 1'b0;
      unique case (st_q)
        StRun: begin
          pwm_c = cmp_q;
          in1_c = app_q[1];
          in2_c = app_q[0];
        end
        StBrake: begin
          pwm_c = 1'b1;
          in1_c = 1'b1;
          in2_c = 1'b1;
        end
        default: ;
      endcase
    end

`ifdef PORNIRE_LINA_EN
    logic [11:0] ramp_q, ramp_d;
    logic [12:0] ramp_sum;

    always_comb begin
      ramp_sum = {1'b0, ramp_q} + 13'(RAMP_STEP);
      ramp_d   = ramp_q;
      if (st_q == StDead && st_d == StRun) begin
        ramp_d = '0;
      end else if (wrap) begin
        ramp_d = (ramp_sum >= {1'b0, duty_sat}) ? duty_sat : ramp_sum[11:0];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ramp_q <= '0;
      end else begin
        ramp_q <= ramp_d;
      end
    end

    // A lowered target wins over the ramp at once.
    assign duty_eff = (ramp_q < duty_q) ? ramp_q : duty_q;
`else
    assign duty_eff = duty_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q   <= StStop;
        app_q  <= 2'b00;
        dead_q <= '0;
        duty_q <= '0;
        cmp_q  <= 1'b0;
      end else begin
        st_q   <= st_d;
        app_q  <= app_d;
        dead_q <= dead_d;
        if (wrap) begin
          duty_q <= duty_sat;
        end
        cmp_q  <= (12'(cnt_q) < duty_eff);
      end
    end

    assign pwm_v[c]    = pwm_c;
    assign in1_v[c]    = in1_c;
    assign in2_v[c]    = in2_c;
    assign dead_nxt[c] = (st_d == StDead);
  end

  // Built from next state so the flag lines up exactly with the DEAD cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mort_q <= 1'b0;
    end else begin
      mort_q <= |dead_nxt;
    end
  end

  assign pwm_a         = pwm_v[0];
  assign pwm_b         = pwm_v[1];
  assign in1_a         = in1_v[0];
  assign in2_a         = in2_v[0];
  assign in1_b         = in1_v[1];
  assign in2_b         = in2_v[1];
  assign perioada_tick = tick_q;
  assign mort_activ    = mort_q;

endmodule
